// File: rtl/bf_io_pkg.sv
// -----------------------------------------------------------------------------
// bf_io_pkg
// Shared definitions for the Brainfuck CPU serial I/O stages.
//   rx_state_t : receiver FSM states (IDLE, START, DATA, STOP)
//   bf_char_t  : one character on the core's I/O path
//   calc_div   : board clocks per UART bit, integer-truncated; shared with
//                the serial output stage so both sides agree on bit timing
// -----------------------------------------------------------------------------
package bf_io_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    typedef logic [7:0] bf_char_t;

    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/bf_uart_rx_fifo_if.sv
// -----------------------------------------------------------------------------
// bf_uart_rx_fifo_if
// Core-facing side of the serial input stage.
//   pop       : core -> FIFO, one-cycle pulse consuming the head character
//   char      : FIFO -> core, head character (meaningful while valid=1)
//   valid     : FIFO -> core, FIFO non-empty
//   count     : FIFO -> core, occupancy, $clog2(DEPTH+1) bits
//   overflow  : FIFO -> core, sticky "a received byte was dropped"
//   frame_err : FIFO -> core, one-cycle pulse on a bad stop bit
// Modports: master = core side, slave = FIFO side.
// -----------------------------------------------------------------------------
interface bf_uart_rx_fifo_if #(
    parameter int DEPTH = 16
);
    import bf_io_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             pop;
    bf_char_t         char;
    logic             valid;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             frame_err;

    modport master (
        output pop,
        input  char,
        input  valid,
        input  count,
        input  overflow,
        input  frame_err
    );

    modport slave (
        input  pop,
        output char,
        output valid,
        output count,
        output overflow,
        output frame_err
    );

endinterface

// File: rtl/bf_uart_rx_deser.sv
// -----------------------------------------------------------------------------
// bf_uart_rx_deser
// 8N1 UART deserialiser: 2-flop synchroniser, receiver FSM, shift register.
// Optional feature macro: BF_RX_FRAME_CHECK_EN (stop-bit check, frame_err).
// Ports:
//   clk, nrst  : board clock, asynchronous active-low reset
//   uart_rx    : raw serial line, idle high, asynchronous to clk
//   rx_byte    : last received byte, held until the next push
//   push       : one-cycle pulse, rx_byte is a new character
//   frame_err  : one-cycle pulse in place of push when the stop bit was 0
//                (constant 0 when the stop-bit check is compiled out)
// -----------------------------------------------------------------------------
module bf_uart_rx_deser
    import bf_io_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic     clk,
    input  logic     nrst,
    input  logic     uart_rx,
    output bf_char_t rx_byte,
    output logic     push,
    output logic     frame_err
);

    localparam int DIV   = calc_div(CLK_HZ, BAUD);
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = $clog2(DIV + 1);

    // Synchroniser plus one extra stage used only for falling-edge detection.
    logic sync1_reg;
    logic sync2_reg;
    logic rx_prev_reg;
    logic rx_s;

    rx_state_t        state_reg,   state_next;
    logic [CNT_W-1:0] cnt_reg,     cnt_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    bf_char_t         shift_reg,   shift_next;
    bf_char_t         byte_reg,    byte_next;
    logic             push_reg,    push_next;
    logic             start_edge;
    logic             cnt_expired;

    assign rx_s        = sync2_reg;
    // Edge-triggered start detection: a line parked low (break, or the tail of
    // a bad stop bit) must go high again before a new frame can begin.
    assign start_edge  = rx_prev_reg & ~rx_s;
    // The counter is loaded with the full interval and the sample is taken on
    // the edge after it reaches 1, so a load of N samples exactly N edges later.
    assign cnt_expired = (cnt_reg == CNT_W'(1));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1_reg   <= 1'b1;
            sync2_reg   <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            sync1_reg   <= uart_rx;
            sync2_reg   <= sync1_reg;
            rx_prev_reg <= sync2_reg;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            byte_reg    <= '0;
            push_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            byte_reg    <= byte_next;
            push_reg    <= push_next;
        end
    end

`ifdef BF_RX_FRAME_CHECK_EN
    logic ferr_reg, ferr_next;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ferr_reg <= 1'b0;
        end else begin
            ferr_reg <= ferr_next;
        end
    end

    assign frame_err = ferr_reg;
`else
    assign frame_err = 1'b0;
`endif

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        byte_next    = byte_reg;
        push_next    = 1'b0;
`ifdef BF_RX_FRAME_CHECK_EN
        ferr_next    = 1'b0;
`endif

        case (state_reg)
            IDLE: begin
                if (start_edge) begin
                    cnt_next   = CNT_W'(HALF);
                    state_next = START;
                end
            end

            START: begin
                if (cnt_expired) begin
                    if (!rx_s) begin
                        cnt_next     = CNT_W'(DIV);
                        bit_idx_next = '0;
                        state_next   = DATA;
                    end else begin
                        // Line went back high before mid-start-bit: glitch.
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end

            DATA: begin
                if (cnt_expired) begin
                    shift_next = {rx_s, shift_reg[7:1]};
                    cnt_next   = CNT_W'(DIV);
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end

            STOP: begin
                if (cnt_expired) begin
                    state_next = IDLE;
`ifdef BF_RX_FRAME_CHECK_EN
                    if (rx_s) begin
                        byte_next = shift_reg;
                        push_next = 1'b1;
                    end else begin
                        ferr_next = 1'b1;
                    end
`else
                    byte_next = shift_reg;
                    push_next = 1'b1;
`endif
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end

            default: state_next = IDLE;
        endcase
    end

    assign rx_byte = byte_reg;
    assign push    = push_reg;

endmodule

// File: rtl/bf_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// bf_uart_rx_fifo
// Serial input stage for the Brainfuck CPU: 8N1 receiver feeding a
// show-ahead FIFO that the core drains with single-cycle pop pulses.
// Optional feature macro: BF_RX_FRAME_CHECK_EN (drop bytes with a bad stop bit
// and pulse frame_err; otherwise the stop bit is ignored).
// Ports:
//   clk     : board clock (single clock domain)
//   nrst    : asynchronous active-low reset
//   uart_rx : serial line from the host, idle high
//   rx_if   : slave modport of bf_uart_rx_fifo_if
//             (pop in; char, valid, count, overflow, frame_err out)
// Parameters: CLK_HZ, BAUD (bit period = CLK_HZ/BAUD), DEPTH (power of two, >=2)
// -----------------------------------------------------------------------------
module bf_uart_rx_fifo
    import bf_io_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              uart_rx,
    bf_uart_rx_fifo_if.slave  rx_if
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    bf_char_t rx_byte;
    logic     push;
    logic     frame_err;

    bf_uart_rx_deser #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_deser (
        .clk       (clk),
        .nrst      (nrst),
        .uart_rx   (uart_rx),
        .rx_byte   (rx_byte),
        .push      (push),
        .frame_err (frame_err)
    );

    bf_char_t         mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             overflow_reg;

    logic valid;
    logic full;
    logic pop_ok;
    logic wr_ok;

    assign valid  = (count_reg != '0);
    assign full   = (count_reg == CNT_W'(DEPTH));
    assign pop_ok = rx_if.pop & valid;
    // A pop in the same cycle frees the head slot, so a push into a full FIFO
    // still lands at the tail without overflow.
    assign wr_ok  = push & (~full | pop_ok);

    always_comb begin
        count_next = count_reg;
        case ({wr_ok, pop_ok})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // Storage is not reset; the pointers and count define which entries matter.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_reg] <= rx_byte;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (wr_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (push && !wr_ok) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Show-ahead head; forced to 0 when empty so stale storage never shows.
    assign rx_if.char      = valid ? mem[rd_ptr_reg] : '0;
    assign rx_if.valid     = valid;
    assign rx_if.count     = count_reg;
    assign rx_if.overflow  = overflow_reg;
    assign rx_if.frame_err = frame_err;

endmodule

// File: doc/bf_uart_rx_fifo.md
# bf_uart_rx_fifo

Serial input stage for the Brainfuck CPU: receives 8N1 UART characters from the host, buffers them in a small FIFO, and presents them to the core as a byte plus valid flag for the `,` (read) instruction. It sits upstream of the core's input path and mirrors the serial output stage on the transmit side. It runs on the fast board clock, not the divided CPU clock. The core consumes characters with a single-cycle pop pulse.

## Interface
- `CLK_HZ`, 50_000_000, board clock frequency in Hz.
- `BAUD`, 115200, line rate.
- `DEPTH`, 16, FIFO entries; must be a power of two, ≥2.
- `clk  input  1`  board clock; everything in this block is on this single clock.
- `nrst  input  1`  reset, asynchronous, active-low.
- `uart_rx  input  1`  serial line, idle high, asynchronous to `clk`.
- `pop  input  1`  one-cycle pulse; consume the head character.
- `char  output  8`  head of FIFO; valid only while `valid`=1.
- `valid  output  1`  FIFO non-empty.
- `count  output  $clog2(DEPTH+1)`  current occupancy.
- `overflow  output  1`  sticky; a received byte was dropped because the FIFO was full.
- `frame_err  output  1`  one-cycle pulse on a bad stop bit (only with `BF_RX_FRAME_CHECK_EN`).

## Operation
- Reset values: `char`=0, `valid`=0, `count`=0, `overflow`=0, `frame_err`=0. Receiver state is IDLE. Synchroniser flops are 1. FIFO pointers are 0.
- `uart_rx` passes through a 2-flop synchroniser. All decisions use the synchronised value.
- Bit period is `DIV = CLK_HZ/BAUD`, integer-truncated (434 at defaults). Half period is `DIV/2`.
- Receiver FSM:
  - IDLE: on a synchronised high→low transition, load the counter with `DIV/2` and go to START.
  - START: when the counter expires, sample the line. Low: go to DATA with bit index 0 and reload `DIV`. High: glitch; return to IDLE, nothing is pushed.
  - DATA: each `DIV` expiry samples one bit into the shift register, LSB first. After bit 7, go to STOP.
  - STOP: on `DIV` expiry, sample the stop bit, issue a push (subject to the frame check), and return to IDLE.
  - IDLE then waits for the next falling edge. A line held low does not retrigger.
- FIFO is show-ahead: `char` always reflects the head entry.
  - Push when not full: write at the write pointer; `count`+1.
  - Push when full and no pop: drop the byte; set `overflow` (cleared only by `nrst`).
  - Pop when `valid`=1: advance the read pointer; `count`−1.
  - Pop when `valid`=0: ignored; no underflow.
  - Simultaneous push and pop: both take effect and `count` is unchanged. This also holds when full, so the push is accepted and `overflow` is not set.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`. Full/empty are derived from `count`.
- Asserting `nrst` mid-frame aborts the frame, empties the FIFO, and discards any partial byte.

## Timing
- The push occurs in the cycle after the stop-bit sample. `valid`/`char`/`count` update on the next edge.
- Latency from the start-bit falling edge on the pin to `valid`: 2 (synchroniser) + DIV/2 + 9·DIV + 2 cycles.
- After `pop`, `char` shows the next entry and `count` decrements on the following edge.
- `frame_err` is high for exactly the one cycle in which the push would have occurred.

## Configuration
- `BF_RX_FRAME_CHECK_EN` defined:
  - A stop-bit sample of 0 discards the byte and pulses `frame_err`.
  - The receiver then waits in IDLE for the line to return high before arming start detection.
- Not defined:
  - The stop-bit sample is ignored and every byte is pushed.
  - `frame_err` is tied to 0.

## Structure
- Shared package `bf_io_pkg`: receiver state enum (IDLE, START, DATA, STOP), a `bf_char_t` 8-bit typedef, and a `DIV` computation function shared with the serial output stage.
- Sub-module `bf_uart_rx_deser` contains the synchroniser, FSM, and shift register, and outputs `byte` plus a one-cycle `push`. The FIFO and its flags live in `bf_uart_rx_fifo`.

## Test plan
- Reset, then send 0x41 ('A') at 115200 → `valid` rises at the computed latency, `char`=0x41, `count`=1; a `pop` gives `valid`=0 and `count`=0.
- Send 0x00, 0xFF, 0x5A back to back with no pops → `count`=3; successive pops yield 0x00, 0xFF, 0x5A in order.
- Send 17 bytes with `DEPTH`=16 and no pops → `count`=16, `overflow`=1, the 17th byte is lost; 16 pops return bytes 1–16.
- Hold the FIFO full and pulse `pop` in the push cycle of a new byte → `count` stays 16, the new byte lands at the tail, `overflow` stays 0.
- Apply a 100-cycle low glitch on `uart_rx` → nothing pushed. Send a frame with the stop bit forced to 0 → with the macro, a `frame_err` pulse and `count` unchanged; without it, the byte is pushed.
- Assert `nrst` during DATA bit 4 → all outputs return to reset values; the next clean frame is received correctly.
